serv_mtimer: RTL

SERV_MTIMER -- requirements
Module: serv_mtimer

---
 rtl/serv_mtimer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serv_mtimer.sv
// serv_mtimer: RISC-V machine timer (64-bit mtime/mtimecmp driving o_mtip) behind a Wishbone classic slave.
// Define SERV_MTIMER_PRESCALE_EN to build the tick prescaler register at address 4.
module serv_mtimer #(
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  localparam logic [2:0]  ADR_MTIME_LO = 3'd0;
  localparam logic [2:0]  ADR_MTIME_HI = 3'd1;
  localparam logic [2:0]  ADR_CMP_LO   = 3'd2;
  localparam logic [2:0]  ADR_CMP_HI   = 3'd3;
  localparam logic [2:0]  ADR_PRESCALE = 3'd4;
  localparam logic [63:0] MTIME_ONE    = 64'd1;

  if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_bad_prescale_w
    $error("serv_mtimer: PRESCALE_W must be in 1..32");
  end

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdt_q, rdt_d;
  logic        ack_q, ack_d;
  logic        mtip_q, mtip_d;

  logic        bus_acc;
  logic        bus_wr;
  logic        bus_rd;
  logic        tick;

  // An access is taken only on the edge that raises ack, so a held cyc
  // commits once per ack and back-to-back requests alternate.
  assign bus_acc = i_wb_cyc & ~ack_q;
  assign bus_wr  = bus_acc & i_wb_we;
  assign bus_rd  = bus_acc & ~i_wb_we;

`ifdef SERV_MTIMER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = 1;

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [31:0]           prescale_rdt;

  always_comb begin
    tick        = (presc_cnt_q == prescale_q);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_ONE;
    prescale_d  = prescale_q;
    if (bus_wr && (i_wb_adr == ADR_PRESCALE)) begin
      prescale_d  = i_wb_dat[PRESCALE_W-1:0];
      presc_cnt_d = '0;
    end
    prescale_rdt                   = '0;
    prescale_rdt[PRESCALE_W-1:0]   = prescale_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescale_q  <= '0;
      presc_cnt_q <= '0;
    end else begin
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A bus write to either mtime half wins over the tick and suppresses the carry.
  always_comb begin
    mtime_d = mtime_q;
    if (bus_wr && (i_wb_adr == ADR_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], i_wb_dat};
    end else if (bus_wr && (i_wb_adr == ADR_MTIME_HI)) begin
      mtime_d = {i_wb_dat, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + MTIME_ONE;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (bus_wr && (i_wb_adr == ADR_CMP_LO)) begin
      cmp_d[31:0] = i_wb_dat;
    end
    if (bus_wr && (i_wb_adr == ADR_CMP_HI)) begin
      cmp_d[63:32] = i_wb_dat;
    end
  end

  // Reading the low word latches the high word so a lo-then-hi pair is coherent.
  always_comb begin
    shadow_d = shadow_q;
    if (bus_rd && (i_wb_adr == ADR_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_comb begin
    rdt_d = '0;
    if (bus_rd) begin
      case (i_wb_adr)
        ADR_MTIME_LO: rdt_d = mtime_q[31:0];
        ADR_MTIME_HI: rdt_d = shadow_q;
        ADR_CMP_LO:   rdt_d = cmp_q[31:0];
        ADR_CMP_HI:   rdt_d = cmp_q[63:32];
`ifdef SERV_MTIMER_PRESCALE_EN
        ADR_PRESCALE: rdt_d = prescale_rdt;
`endif
        default:      rdt_d = '0;
      endcase
    end
  end

  always_comb begin
    ack_d  = bus_acc;
    mtip_d = (mtime_q >= cmp_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q  <= '0;
      cmp_q    <= CMP_RESET;
      shadow_q <= '0;
      rdt_q    <= '0;
      ack_q    <= 1'b0;
      mtip_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdt_q    <= rdt_d;
      ack_q    <= ack_d;
      mtip_q   <= mtip_d;
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_mtip   = mtip_q;

endmodule
